// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and data requesters
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              flush_i,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_done_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                last_fetch_q, last_fetch_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                dm_done_q, dm_done_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                err_q, err_d;

  logic                w_grant_data;
  logic                w_grant_fetch;

  // On a tie the requester that did not win last time gets the port.
  assign w_grant_data  = dm_req_i && (!if_req_i || last_fetch_q);
  assign w_grant_fetch = if_req_i && !w_grant_data;

  always_comb begin
    state_d      = state_q;
    last_fetch_d = last_fetch_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_done_d    = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (w_grant_data) begin
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          cnt_d       = 8'd0;
        end else if (w_grant_fetch) begin
          state_d     = ST_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          cnt_d       = 8'd0;
        end
      end

      ST_FETCH, ST_DATA: begin
        if (mem_ack_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (state_q == ST_FETCH) begin
            last_fetch_d = 1'b1;
            // A flush in the ack cycle itself must also suppress the result.
            if (!(drop_q || flush_i)) begin
              if_valid_d = 1'b1;
              if_rdata_d = mem_rdata_i;
            end
          end else begin
            last_fetch_d = 1'b0;
            dm_done_d    = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata_i;
            end
          end
        end else if (cnt_q == c_cnt_last) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (state_q == ST_FETCH) begin
            drop_d = drop_q || flush_i;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      last_fetch_q <= 1'b1;
      cnt_q        <= 8'd0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_done_q    <= 1'b0;
      dm_rdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_fetch_q <= last_fetch_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_done_q    <= dm_done_d;
      dm_rdata_q   <= dm_rdata_d;
      err_q        <= err_d;
    end
  end

  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              flush;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;

  logic              auto_ack;
  logic              man_ack;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Zero-wait memory when auto_ack is set: ack in the first mem_req cycle.
  assign mem_ack = auto_ack ? mem_req : man_ack;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .flush_i    (flush),
    .if_valid_o (if_valid),
    .if_rdata_o (if_rdata),
    .dm_req_i   (dm_req),
    .dm_we_i    (dm_we),
    .dm_addr_i  (dm_addr),
    .dm_wdata_i (dm_wdata),
    .dm_done_o  (dm_done),
    .dm_rdata_o (dm_rdata),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    flush     = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    auto_ack  = 1'b0;
    man_ack   = 1'b0;

    tick();
    tick();
    chk("rst_mem_req",  32'(mem_req),   32'h0);
    chk("rst_mem_we",   32'(mem_we),    32'h0);
    chk("rst_mem_addr", 32'(mem_addr),  32'h0);
    chk("rst_if_valid", 32'(if_valid),  32'h0);
    chk("rst_dm_done",  32'(dm_done),   32'h0);
    chk("rst_if_rdata", 32'(if_rdata),  32'h0);
    chk("rst_err",      32'(err),       32'h0);
    reset = 1'b0;
    tick();
    chk("idle_no_req",  32'(mem_req),   32'h0);

    // Single fetch, zero-wait memory
    if_req  = 1'b1;
    if_addr = 20'h00020;
    tick();
    chk("f1_mem_req",  32'(mem_req),  32'h1);
    chk("f1_mem_addr", 32'(mem_addr), 32'h00020);
    chk("f1_mem_we",   32'(mem_we),   32'h0);
    chk("f1_no_valid", 32'(if_valid), 32'h0);
    man_ack   = 1'b1;
    mem_rdata = 16'hA5A5;
    if_req    = 1'b0;
    tick();
    chk("f1_valid",    32'(if_valid), 32'h1);
    chk("f1_rdata",    32'(if_rdata), 32'hA5A5);
    chk("f1_req_drop", 32'(mem_req),  32'h0);
    man_ack = 1'b0;
    tick();
    chk("f1_valid_pulse", 32'(if_valid), 32'h0);
    chk("f1_idle_req",    32'(mem_req),  32'h0);

    // Both requesters held: DATA, FETCH, DATA, FETCH
    if_req    = 1'b1;
    if_addr   = 20'h00100;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 20'h00200;
    mem_rdata = 16'h5A5A;
    auto_ack  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_mem_req",  32'(mem_req),  32'h1);
      chk("rr_mem_addr", 32'(mem_addr), (k % 2 == 0) ? 32'h00200 : 32'h00100);
      if (k == 3) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      tick();
      chk("rr_dm_done",  32'(dm_done),  (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_if_valid", 32'(if_valid), (k % 2 == 0) ? 32'h0 : 32'h1);
      chk("rr_idle_req", 32'(mem_req),  32'h0);
    end
    auto_ack = 1'b0;
    chk("rr_dm_rdata", 32'(dm_rdata), 32'h5A5A);
    chk("rr_if_rdata", 32'(if_rdata), 32'h5A5A);
    tick();
    chk("rr_stays_idle", 32'(mem_req), 32'h0);

    // Store, 3-cycle memory latency
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 20'h000FF;
    dm_wdata = 16'h1234;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("st_mem_req",   32'(mem_req),   32'h1);
      chk("st_mem_we",    32'(mem_we),    32'h1);
      chk("st_mem_addr",  32'(mem_addr),  32'h000FF);
      chk("st_mem_wdata", 32'(mem_wdata), 32'h1234);
      chk("st_no_done",   32'(dm_done),   32'h0);
      if (c == 2) dm_wdata = 16'hFFFF;
    end
    man_ack = 1'b1;
    dm_req  = 1'b0;
    tick();
    chk("st_done",     32'(dm_done), 32'h1);
    chk("st_req_drop", 32'(mem_req), 32'h0);
    man_ack = 1'b0;
    tick();
    chk("st_done_pulse", 32'(dm_done), 32'h0);

    // Flush one cycle after a fetch grant, latency 2
    if_req  = 1'b1;
    if_addr = 20'h00040;
    tick();
    chk("fl_mem_req", 32'(mem_req), 32'h1);
    flush = 1'b1;
    tick();
    chk("fl_req_held", 32'(mem_req), 32'h1);
    flush     = 1'b0;
    man_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    chk("fl_no_valid", 32'(if_valid), 32'h0);
    chk("fl_rdata",    32'(if_rdata), 32'h5A5A);
    chk("fl_req_drop", 32'(mem_req),  32'h0);
    man_ack   = 1'b0;
    mem_rdata = 16'hC0DE;
    tick();
    chk("fl_regrant", 32'(mem_req),  32'h1);
    chk("fl_addr",    32'(mem_addr), 32'h00040);
    man_ack = 1'b1;
    tick();
    chk("fl_next_valid", 32'(if_valid), 32'h1);
    chk("fl_next_rdata", 32'(if_rdata), 32'hC0DE);
    if_req  = 1'b0;
    man_ack = 1'b0;
    tick();

    // Timeout: memory never acks
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 20'h00300;
    tick();
    chk("to_req_first", 32'(mem_req), 32'h1);
    for (int i = 2; i <= TIMEOUT; i++) begin
      tick();
      chk("to_req_held", 32'(mem_req), 32'h1);
    end
    chk("to_err_before", 32'(err), 32'h0);
    tick();
    chk("to_req_drop", 32'(mem_req), 32'h0);
    chk("to_err",      32'(err),     32'h1);
    chk("to_no_done",  32'(dm_done), 32'h0);
    tick();
    chk("to_regrant",   32'(mem_req),  32'h1);
    chk("to_addr",      32'(mem_addr), 32'h00300);
    man_ack   = 1'b1;
    mem_rdata = 16'h7777;
    tick();
    chk("to_done",   32'(dm_done),  32'h1);
    chk("to_rdata",  32'(dm_rdata), 32'h7777);
    chk("to_sticky", 32'(err),      32'h1);
    man_ack = 1'b0;
    dm_req  = 1'b0;
    tick();
    chk("to_sticky2", 32'(err), 32'h1);

    // Async reset mid DATA access, then tie goes to data
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 20'h00055;
    dm_wdata = 16'h0099;
    tick();
    chk("ra_mem_req", 32'(mem_req), 32'h1);
    if_req  = 1'b1;
    if_addr = 20'h00066;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("ra_req_async", 32'(mem_req),  32'h0);
    chk("ra_err_clr",   32'(err),      32'h0);
    chk("ra_addr_clr",  32'(mem_addr), 32'h0);
    chk("ra_dm_rdata",  32'(dm_rdata), 32'h0);
    tick();
    chk("ra_no_done", 32'(dm_done), 32'h0);
    reset = 1'b0;
    tick();
    chk("ra_grant_req",  32'(mem_req),  32'h1);
    chk("ra_grant_addr", 32'(mem_addr), 32'h00055);
    chk("ra_grant_we",   32'(mem_we),   32'h1);
    man_ack = 1'b1;
    dm_req  = 1'b0;
    tick();
    chk("ra_done", 32'(dm_done), 32'h1);
    man_ack = 1'b0;
    tick();
    chk("ra_fetch_next", 32'(mem_addr), 32'h00066);
    chk("ra_fetch_we",   32'(mem_we),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
